vend_credit_ctrl: RTL and testbench

- Vending-machine credit controller, directly downstream of the UART driver.
- Consumes its confirm, quarter and dime pulses, accumulates credit, and decides vend or refused purchase.
- Feeds back the give_change strobe and the 12-bit BCD amount that the UART transmit path reports.
- Contains an iterative binary-to-BCD converter so the BCD amount always tracks the binary credit.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_credit_ctrl_bin2bcd.sv | 58 +++++
 rtl/vend_credit_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the FSM state encoding, coin values and the BCD adjust step.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        CHANGE
    } state_t;

    localparam int QUARTER_C = 25;
    localparam int DIME_C    = 10;
    localparam int BCD_W     = 12;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [BCD_W-1:0] bcdAdjust(input logic [BCD_W-1:0] value);
        logic [BCD_W-1:0] result;
        result = value;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (value[i*4 +: 4] >= 4'd5) begin
                result[i*4 +: 4] = value[i*4 +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vend_credit_ctrl_bin2bcd.sv
// Iterative double-dabble converter, one bit per cycle.
// A start pulse latches a new value and aborts any conversion in flight.
module bin2bcd_seq
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CREDIT_W-1:0] bin,
    output logic [BCD_W-1:0]    bcd,
    output logic                done
);

    localparam int CNT_W = $clog2(CREDIT_W + 1);
    localparam int SR_W  = BCD_W + CREDIT_W;

    logic [SR_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_count;
    logic             r_running;
    logic [BCD_W-1:0] r_bcd;
    logic             r_done;
    logic [SR_W-1:0]  w_shifted;

    // BCD digits sit above the remaining binary bits; both move left together.
    always_comb begin
        w_shifted = {bcdAdjust(r_shift[SR_W-1 -: BCD_W]), r_shift[CREDIT_W-1:0]} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
            r_bcd     <= '0;
            r_done    <= 1'b1;
        end else if (start) begin
            r_shift   <= {{BCD_W{1'b0}}, bin};
            r_count   <= CNT_W'(CREDIT_W);
            r_running <= 1'b1;
            r_done    <= 1'b0;
        end else if (r_running) begin
            if (r_count != '0) begin
                r_shift <= w_shifted;
                r_count <= r_count - CNT_W'(1);
            end else begin
                r_bcd     <= r_shift[SR_W-1 -: BCD_W];
                r_done    <= 1'b1;
                r_running <= 1'b0;
            end
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: counts coin edges, decides vend/refusal,
// and reports change as BCD through an iterative converter.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 75,
    parameter int MAX_CREDIT = 995,
    parameter int CREDIT_W   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                quarter_in,
    input  logic                dime_in,
    input  logic                confirm_in,
    input  logic                cancel_in,
    output logic [CREDIT_W-1:0] credit_bin,
    output logic [BCD_W-1:0]    amount_bcd,
    output logic                bcd_valid,
    output logic                vend,
    output logic                give_change,
    output logic                insufficient,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [CREDIT_W:0] L_PRICE   = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0] L_MAX     = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0] L_QUARTER = (CREDIT_W + 1)'(QUARTER_C);
    localparam logic [CREDIT_W:0] L_DIME    = (CREDIT_W + 1)'(DIME_C);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_creditLast;
    logic                r_quarterQ;
    logic                r_dimeQ;
    logic                r_confirmQ;
    logic                r_cancelQ;
    logic                r_vend;
    logic                r_giveChange;
    logic                r_insufficient;
    logic                r_coinReject;

    state_t              w_stateNext;
    logic [CREDIT_W-1:0] w_creditNext;
    logic [CREDIT_W:0]   w_sum;
    logic                w_vendNext;
    logic                w_giveChangeNext;
    logic                w_insufficientNext;
    logic                w_coinRejectNext;
    logic                w_quarterRise;
    logic                w_dimeRise;
    logic                w_confirmRise;
    logic                w_cancelRise;
    logic                w_start;
    logic                w_done;

    assign w_quarterRise = quarter_in & ~r_quarterQ;
    assign w_dimeRise    = dime_in & ~r_dimeQ;
    assign w_confirmRise = confirm_in & ~r_confirmQ;
    assign w_cancelRise  = cancel_in & ~r_cancelQ;

    // Any change of the stored credit restarts the converter on the next edge.
    assign w_start   = (r_credit != r_creditLast);
    assign bcd_valid = w_done & ~w_start;

    bin2bcd_seq #(
        .CREDIT_W (CREDIT_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (r_credit),
        .bcd   (amount_bcd),
        .done  (w_done)
    );

    always_comb begin
        w_stateNext        = r_state;
        w_creditNext       = r_credit;
        w_sum              = {1'b0, r_credit};
        w_vendNext         = 1'b0;
        w_giveChangeNext   = 1'b0;
        w_insufficientNext = 1'b0;
        w_coinRejectNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_quarterRise) begin
                    if (w_sum + L_QUARTER > L_MAX) w_coinRejectNext = 1'b1;
                    else                           w_sum = w_sum + L_QUARTER;
                end
                if (w_dimeRise) begin
                    if (w_sum + L_DIME > L_MAX) w_coinRejectNext = 1'b1;
                    else                        w_sum = w_sum + L_DIME;
                end
                // Confirm sees the credit including this cycle's coins and beats cancel.
                if (w_confirmRise) begin
                    if (w_sum >= L_PRICE) begin
                        w_creditNext = CREDIT_W'(w_sum - L_PRICE);
                        w_vendNext   = 1'b1;
                        w_stateNext  = CONVERT;
                    end else begin
                        w_creditNext       = CREDIT_W'(w_sum);
                        w_insufficientNext = 1'b1;
                    end
                end else begin
                    w_creditNext = CREDIT_W'(w_sum);
                    if (w_cancelRise) w_stateNext = CONVERT;
                end
            end
            CONVERT: begin
                w_coinRejectNext = w_quarterRise | w_dimeRise;
                if (bcd_valid) begin
                    w_stateNext      = CHANGE;
                    w_giveChangeNext = 1'b1;
                end
            end
            CHANGE: begin
                w_coinRejectNext = w_quarterRise | w_dimeRise;
                w_creditNext     = '0;
                w_stateNext      = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_creditLast   <= '0;
            r_quarterQ     <= 1'b0;
            r_dimeQ        <= 1'b0;
            r_confirmQ     <= 1'b0;
            r_cancelQ      <= 1'b0;
            r_vend         <= 1'b0;
            r_giveChange   <= 1'b0;
            r_insufficient <= 1'b0;
            r_coinReject   <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_credit       <= w_creditNext;
            r_creditLast   <= r_credit;
            r_quarterQ     <= quarter_in;
            r_dimeQ        <= dime_in;
            r_confirmQ     <= confirm_in;
            r_cancelQ      <= cancel_in;
            r_vend         <= w_vendNext;
            r_giveChange   <= w_giveChangeNext;
            r_insufficient <= w_insufficientNext;
            r_coinReject   <= w_coinRejectNext;
        end
    end

    assign credit_bin   = r_credit;
    assign vend         = r_vend;
    assign give_change  = r_giveChange;
    assign insufficient = r_insufficient;
    assign coin_reject  = r_coinReject;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: a credit model queues expected pulses,
// and a monitor pops and compares them whenever the DUT emits a pulse.
module tb_vend_credit_ctrl;

    localparam int PRICE = 75;
    localparam int MAXC  = 995;

    logic        clk = 1'b0;
    logic        reset;
    logic        quarter_in, dime_in, confirm_in, cancel_in;
    logic [9:0]  credit_bin;
    logic [11:0] amount_bcd;
    logic        bcd_valid, vend, give_change, insufficient, coin_reject, busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int mCredit     = 0;

    typedef struct {
        bit          vend;
        bit          insuf;
        bit          reject;
        bit          change;
        logic [11:0] amount;
    } expect_t;

    expect_t expQ[$];

    vend_credit_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .quarter_in   (quarter_in),
        .dime_in      (dime_in),
        .confirm_in   (confirm_in),
        .cancel_in    (cancel_in),
        .credit_bin   (credit_bin),
        .amount_bcd   (amount_bcd),
        .bcd_valid    (bcd_valid),
        .vend         (vend),
        .give_change  (give_change),
        .insufficient (insufficient),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] toBcd(input int value);
        return {4'(value / 100), 4'((value / 10) % 10), 4'(value % 10)};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic pushIfPulse(input expect_t e);
        if (e.vend || e.insuf || e.reject || e.change) expQ.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_returns_low", busy, 0);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!bcd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bcd_valid_settles", bcd_valid, 1);
        checkOutput("amount_bcd_settled", amount_bcd, toBcd(mCredit));
    endtask

    // One IDLE transaction: model the expected result, drive one rising edge, then release.
    task automatic applyStimulus(input bit q, input bit d, input bit c, input bit x, input bit inject);
        expect_t e;
        int      s;
        bit      toChange;
        e        = '{default: 0};
        s        = mCredit;
        toChange = 1'b0;
        if (q) begin
            if (s + 25 > MAXC) e.reject = 1'b1;
            else               s += 25;
        end
        if (d) begin
            if (s + 10 > MAXC) e.reject = 1'b1;
            else               s += 10;
        end
        if (c) begin
            if (s >= PRICE) begin
                s -= PRICE;
                e.vend   = 1'b1;
                toChange = 1'b1;
            end else begin
                e.insuf = 1'b1;
            end
        end else if (x) begin
            toChange = 1'b1;
        end
        mCredit = s;
        pushIfPulse(e);
        quarter_in = q; dime_in = d; confirm_in = c; cancel_in = x;
        @(negedge clk);
        quarter_in = 0; dime_in = 0; confirm_in = 0; cancel_in = 0;
        checkOutput("credit_bin", credit_bin, mCredit);
        checkOutput("busy_after_request", busy, int'(toChange));
        if (toChange) begin
            if (inject && e.vend) begin
                @(negedge clk);
                e = '{default: 0};
                e.reject = 1'b1;
                pushIfPulse(e);
                if ($urandom_range(0, 1) == 1) quarter_in = 1;
                else                           dime_in = 1;
                @(negedge clk);
                quarter_in = 0; dime_in = 0;
            end
            e = '{default: 0};
            e.change = 1'b1;
            e.amount = toBcd(mCredit);
            pushIfPulse(e);
            waitIdle();
            mCredit = 0;
            checkOutput("credit_cleared", credit_bin, 0);
        end else begin
            @(negedge clk);
        end
    endtask

    // Monitor: every emitted pulse must match the oldest queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (vend || insufficient || coin_reject || give_change) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {vend, insufficient, coin_reject, give_change}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulses", {vend, insufficient, coin_reject, give_change},
                                {e.vend, e.insuf, e.reject, e.change});
                    if (e.change) begin
                        checkOutput("change_amount", amount_bcd, e.amount);
                        checkOutput("change_bcd_valid", bcd_valid, 1);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        int lowCount;
        int n;
        reset = 1; quarter_in = 0; dime_in = 0; confirm_in = 0; cancel_in = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_credit", credit_bin, 0);
        checkOutput("reset_amount", amount_bcd, 0);
        checkOutput("reset_bcd_valid", bcd_valid, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pulses", {vend, insufficient, coin_reject, give_change}, 0);
        reset = 0;
        @(negedge clk);

        // Exact price: vend, zero change.
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // 110 cents: vend leaves 35 as change.
        repeat (4) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // Not enough credit.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        waitValid();
        applyStimulus(0, 0, 0, 1, 0);

        // Credit ceiling.
        repeat (38) applyStimulus(1, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0, 0);
        waitValid();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1);

        // Same-cycle quarter and dime, with converter latency.
        waitValid();
        quarter_in = 1; dime_in = 1;
        @(negedge clk);
        quarter_in = 0; dime_in = 0;
        mCredit += 35;
        checkOutput("both_coins_credit", credit_bin, mCredit);
        lowCount = 0;
        while (!bcd_valid && lowCount < 40) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput("bcd_latency_cycles", lowCount, 12);
        checkOutput("both_coins_amount", amount_bcd, 12'h035);
        applyStimulus(0, 0, 0, 1, 0);

        // A held level counts once.
        quarter_in = 1;
        repeat (3) @(negedge clk);
        quarter_in = 0;
        @(negedge clk);
        mCredit += 25;
        checkOutput("held_level_once", credit_bin, mCredit);

        // Confirm beats cancel.
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) applyStimulus(1, 0, 0, 0, 0);
            else if (r < 60) applyStimulus(0, 1, 0, 0, 0);
            else if (r < 70) applyStimulus(1, 1, 0, 0, 0);
            else if (r < 85) applyStimulus(0, 0, 1, 0, 1'($urandom_range(0, 1)));
            else if (r < 92) applyStimulus(0, 0, 0, 1, 0);
            else if (r < 96) applyStimulus(0, 0, 1, 1, 0);
            else             applyStimulus(1, 0, 1, 0, 1'($urandom_range(0, 1)));
        end
        waitValid();

        // Reset during CONVERT aborts the refund silently.
        applyStimulus(0, 0, 0, 1, 0);
        waitValid();
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        cancel_in = 1;
        @(negedge clk);
        cancel_in = 0;
        checkOutput("cancel_busy", busy, 1);
        @(negedge clk);
        reset = 1;
        #1;
        checkOutput("abort_credit", credit_bin, 0);
        checkOutput("abort_amount", amount_bcd, 0);
        checkOutput("abort_bcd_valid", bcd_valid, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pulses", {vend, insufficient, coin_reject, give_change}, 0);
        repeat (3) @(negedge clk);
        reset = 0;
        mCredit = 0;
        repeat (15) @(negedge clk);
        checkOutput("post_abort_busy", busy, 0);
        checkOutput("post_abort_credit", credit_bin, 0);

        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
